// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the RV32M multiply/divide unit
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - 32-step shift datapath shared by shift-add multiply and restoring divide
// {hi,lo} holds the running product (MUL) or remainder/quotient (DIV); next values are exported.
module muldiv_iter_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_b,
  output logic [CNT_W-1:0] o_cnt,
  output logic [XLEN-1:0]  o_hi_next,
  output logic [XLEN-1:0]  o_lo_next
);

  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN:0]    w_sum;
  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_diff;

  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_b};
    o_hi_next = w_sum[XLEN:1];
    o_lo_next = {w_sum[0], r_lo[XLEN-1:1]};
    if (i_div) begin
      // a borrow out of the trial subtraction means the divisor did not fit: restore
      if (!w_diff[XLEN]) begin
        o_hi_next = w_diff[XLEN-1:0];
        o_lo_next = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        o_hi_next = w_shift[XLEN-1:0];
        o_lo_next = {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_cnt <= CNT_W'(XLEN - 1);
    end else if (i_step) begin
      r_hi  <= o_hi_next;
      r_lo  <= o_lo_next;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - EX-stage RV32M multiply/divide unit with FSM, sign fix-up and special cases
// MULDIV_FAST_MUL_EN selects a single-cycle 33x33 multiplier for the MUL family.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  import muldiv_pkg::*;

  state_e            r_state;
  state_e            w_state_next;
  logic [2:0]        r_funct3;
  logic              r_neg;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  funct3_e           w_f3;
  logic              w_accept;
  logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0]   w_special_res;
  logic              w_core_load, w_core_step, w_iter_last, w_fast_mul;
  logic [CNT_W-1:0]  w_cnt;
  logic [XLEN-1:0]   w_hi_next, w_lo_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_iter_res, w_fast_res;

  assign w_f3       = funct3_e'(funct3);
  assign w_accept   = (r_state == S_IDLE) && start && !kill;
  assign w_a_signed = (w_f3 == F3_MULH) || (w_f3 == F3_MULHSU) || (w_f3 == F3_DIV) || (w_f3 == F3_REM);
  assign w_b_signed = (w_f3 == F3_MULH) || (w_f3 == F3_DIV) || (w_f3 == F3_REM);
  assign w_a_neg    = w_a_signed & op_a[XLEN-1];
  assign w_b_neg    = w_b_signed & op_b[XLEN-1];
  assign w_a_mag    = cond_neg(op_a, w_a_neg);
  assign w_b_mag    = cond_neg(op_b, w_b_neg);
  // remainder follows the dividend sign; products and quotients follow the sign xor
  assign w_neg      = (w_f3 == F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero = funct3[2] && (op_b == '0);
  assign w_div_ovf  = ((w_f3 == F3_DIV) || (w_f3 == F3_REM)) && (op_a == INT_MIN) && (op_b == '1);
  assign w_special  = w_div_zero || w_div_ovf;
  assign w_special_res = w_div_zero ? (funct3[1] ? op_a : DIV_BY_ZERO_Q)
                                    : (funct3[1] ? '0 : INT_MIN);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] w_fast_prod;
  assign w_fast_prod = $signed({w_a_signed & op_a[XLEN-1], op_a}) * $signed({w_b_signed & op_b[XLEN-1], op_b});
  assign w_fast_res  = (w_f3 == F3_MUL) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
  assign w_fast_mul  = w_accept && !funct3[2];
  assign w_core_load = w_accept && !w_special && funct3[2];
`else
  assign w_fast_res  = '0;
  assign w_fast_mul  = 1'b0;
  assign w_core_load = w_accept && !w_special;
`endif

  assign w_core_step = ((r_state == S_MUL) || (r_state == S_DIV)) && !kill;
  assign w_iter_last = w_core_step && (w_cnt == '0);

  muldiv_iter_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_core_load),
    .i_step    (w_core_step),
    .i_div     (r_state == S_DIV),
    .i_a       (w_a_mag),
    .i_b       (w_b_mag),
    .o_cnt     (w_cnt),
    .o_hi_next (w_hi_next),
    .o_lo_next (w_lo_next)
  );

  assign w_prod     = r_neg ? (~{w_hi_next, w_lo_next} + 1'b1) : {w_hi_next, w_lo_next};
  assign w_iter_res = (r_state == S_DIV) ? cond_neg(r_funct3[1] ? w_hi_next : w_lo_next, r_neg)
                    : ((r_funct3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_special || w_fast_mul) w_state_next = S_DONE;
          else if (funct3[2])          w_state_next = S_DIV;
          else                         w_state_next = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (kill)               w_state_next = S_IDLE;
        else if (w_cnt == '0)   w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_IDLE:       busy = start && !kill && !rst;
      S_MUL, S_DIV: busy = !rst;
      S_DONE:       done = 1'b1;
      default:      busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_funct3 <= '0;
      r_neg    <= 1'b0;
      r_rd     <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      if (w_accept) begin
        r_funct3 <= funct3;
        r_neg    <= w_neg;
        r_rd     <= rd_in;
      end
      if (w_accept && w_special) begin
        r_result <= w_special_res;
        r_rd_out <= rd_in;
      end else if (w_fast_mul) begin
        r_result <= w_fast_res;
        r_rd_out <= rd_in;
      end else if (w_iter_last) begin
        r_result <= w_iter_res;
        r_rd_out <= r_rd;
      end
    end
  end

  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - randomized and directed bench for ex_muldiv_unit against an arithmetic model
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    r  = '0;
    case (f3)
      3'd0: begin up = {32'h0, a} * {32'h0, b}; r = up[31:0]; end
      3'd1: begin sp = longint'(sa) * longint'(sb); r = sp[63:32]; end
      3'd2: begin sp = longint'(sa) * longint'({32'h0, b}); r = sp[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'(sa / sb);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2]) begin
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // start held high through DONE as the pipeline would, operands scrambled after cycle 0
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input string tag);
    int cyc;
    bit got;
    bit busy_bad;
    int lat;
    lat = ref_lat(f3, a, b);
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b0; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
    #1;
    check_eq({tag, " busy_c0"}, 32'(busy), 32'd1);
    cyc = 0; got = 0; busy_bad = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
      #1;
      if (done) got = 1;
      else if (!busy) busy_bad = 1;
    end
    check_eq({tag, " latency"}, 32'(cyc), 32'(lat));
    check_eq({tag, " result"}, result, exp);
    check_eq({tag, " rd_out"}, 32'(rd_out), 32'(rd));
    check_eq({tag, " busy_iter"}, 32'(busy_bad), 32'd0);
    check_eq({tag, " busy_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check_eq({tag, " one_pulse"}, 32'(done), 32'd0);
    check_eq({tag, " no_reexec"}, 32'(busy), 32'd0);
    check_eq({tag, " hold"}, result, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    bit          kdone;

    rst = 1'b1; start = 1'b1; kill = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0; rd_in = '0;
    #12;
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst result", result, 32'h0);
    check_eq("rst rd_out", 32'(rd_out), 32'h0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, "mul");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, "mulhu");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000, "mulh");
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4,  32'hFFFF_FFFF, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, "rem");
    run_op(3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         "remu");
    run_op(3'd4, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, "div0");
    run_op(3'd7, 32'd5,         32'd0,         5'd13, 32'd5,         "remu0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, "divovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0,         "removf");
    run_op(3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        "divu");

    // kill in cycle 10 of a DIVU; previous DIVU result must survive
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b0; funct3 = 3'd5; op_a = 32'd999; op_b = 32'd4; rd_in = 5'd20;
    kdone = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (done) kdone = 1;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    #1;
    check_eq("kill no_done", 32'(kdone | done), 32'd0);
    check_eq("kill idle", 32'(busy), 32'd0);
    check_eq("kill result", result, 32'd14);
    check_eq("kill rd_out", 32'(rd_out), 32'd7);
    run_op(3'd5, 32'd1000, 32'd3, 5'd10, 32'd333, "b2b");

    // asynchronous reset in the middle of a DIV
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd4; op_a = 32'd12345; op_b = 32'd67; rd_in = 5'd11;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst busy", 32'(busy), 32'd0);
    check_eq("arst done", 32'(done), 32'd0);
    check_eq("arst result", result, 32'h0);
    check_eq("arst rd_out", 32'(rd_out), 32'h0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd4, 32'd12345, 32'd67, 5'd11, 32'd184, "post_rst");

    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom);
      run_op(f3, a, b, rd, ref_res(f3, a, b), $sformatf("rnd%0d_f%0d", n, f3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
